// File: rtl/race_game_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// race_game_ctrl_pkg
// Purpose : shared definitions for the race game sequencer and the renderers
//           that sit behind it: state encodings, playfield bounds, start
//           position, level thresholds, scroll divisors and small helpers.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package race_game_ctrl_pkg;

    // Legal player-car window, inclusive on both ends.
    localparam logic [9:0] X_MIN   = 10'd269;
    localparam logic [9:0] X_MAX   = 10'd368;
    localparam logic [9:0] Y_MIN   = 10'd40;
    localparam logic [9:0] Y_MAX   = 10'd429;

    // Car position loaded whenever a new game begins.
    localparam logic [9:0] START_X = 10'd300;
    localparam logic [9:0] START_Y = 10'd429;

    // Score thresholds for levels 1..3 and for the winning score.
    localparam logic [5:0] THR1      = 6'd10;
    localparam logic [5:0] THR2      = 6'd20;
    localparam logic [5:0] THR3      = 6'd30;
    localparam logic [5:0] WIN_SCORE = 6'd40;

    // Frames spent showing the crash / win screen before returning to idle.
    localparam logic [7:0] HOLD_FRAMES = 8'd120;

    // Frames per scroll step at levels 0..3 (all must be >= 1).
    localparam logic [3:0] DIV0 = 4'd4;
    localparam logic [3:0] DIV1 = 4'd3;
    localparam logic [3:0] DIV2 = 4'd2;
    localparam logic [3:0] DIV3 = 4'd1;

    // Low two bits double as the externally visible game_state code;
    // ST_PAUSE is internal only and is reported as PLAY.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_PLAY  = 3'b001,
        ST_CRASH = 3'b010,
        ST_WIN   = 3'b011,
        ST_PAUSE = 3'b100
    } state_t;

    function automatic logic [1:0] level_of(input logic [5:0] s);
        logic [1:0] lv;
        if (s < THR1)      lv = 2'd0;
        else if (s < THR2) lv = 2'd1;
        else if (s < THR3) lv = 2'd2;
        else               lv = 2'd3;
        return lv;
    endfunction

    function automatic logic [3:0] div_of(input logic [1:0] lv);
        logic [3:0] d;
        case (lv)
            2'd0:    d = DIV0;
            2'd1:    d = DIV1;
            2'd2:    d = DIV2;
            default: d = DIV3;
        endcase
        return d;
    endfunction

    function automatic logic [9:0] clamp10(input logic [9:0] v,
                                           input logic [9:0] lo,
                                           input logic [9:0] hi);
        logic [9:0] r;
        if (v < lo)      r = lo;
        else if (v > hi) r = hi;
        else             r = v;
        return r;
    endfunction

endpackage

// File: rtl/race_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// race_game_ctrl_if
// Purpose : bundles every game-side signal of race_game_ctrl.
//   master : firmware / timing side (drives v_sync and the requests, reads
//            the committed game outputs)
//   slave  : the sequencer itself
// Signals :
//   v_sync      DTG vertical sync, active-low
//   start_req   one-cycle pulse, start a game
//   pos_wr      one-cycle pulse, pos_x/pos_y valid
//   pos_x/pos_y requested car position
//   score       current score
//   collision   collision flag, may be a single-cycle pulse
//   pause_req   one-cycle pulse, toggle pause (only with PAUSE_EN)
//   car_x/car_y committed car position
//   level       current level
//   game_state  00 IDLE, 01 PLAY (also while paused), 10 CRASH, 11 WIN
//   scroll_tick one-cycle pulse, advance road/cars one step
//   frame_start one-cycle pulse, one cycle after each v_sync falling edge
//   dbg_state   full internal FSM state, for observation only
// Handshake: all request inputs are valid-only pulses; the sequencer is
//   always ready, so a pulse is consumed on the clock edge it is high, and
//   a pulse arriving in a state that does not accept it is dropped.
// ---------------------------------------------------------------------------
interface race_game_ctrl_if;
    import race_game_ctrl_pkg::*;

    logic        v_sync;
    logic        start_req;
    logic        pos_wr;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [5:0]  score;
    logic        collision;
`ifdef PAUSE_EN
    logic        pause_req;
`endif
    logic [9:0]  car_x;
    logic [9:0]  car_y;
    logic [1:0]  level;
    logic [1:0]  game_state;
    logic        scroll_tick;
    logic        frame_start;
    state_t      dbg_state;

    modport master (
`ifdef PAUSE_EN
        output pause_req,
`endif
        output v_sync, start_req, pos_wr, pos_x, pos_y, score, collision,
        input  car_x, car_y, level, game_state, scroll_tick, frame_start,
               dbg_state
    );

    modport slave (
`ifdef PAUSE_EN
        input  pause_req,
`endif
        input  v_sync, start_req, pos_wr, pos_x, pos_y, score, collision,
        output car_x, car_y, level, game_state, scroll_tick, frame_start,
               dbg_state
    );

endinterface

// File: rtl/race_game_ctrl_frame_tick_gen.sv
// ---------------------------------------------------------------------------
// race_game_ctrl_frame_tick_gen
// Purpose : registers v_sync and detects its falling edge, producing a
//           one-cycle frame_start pulse one cycle after the edge.
// Ports   :
//   clk         in  pixel clock
//   rst         in  synchronous reset, active-high
//   v_sync      in  vertical sync, active-low
//   frame_start out one-cycle pulse
// ---------------------------------------------------------------------------
module race_game_ctrl_frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic v_sync,
    output logic frame_start
);

    logic v_cur;
    logic v_prev;

    // Both stages reset to the inactive (high) level so no pulse is seen
    // straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_cur  <= 1'b1;
            v_prev <= 1'b1;
        end else begin
            v_cur  <= v_sync;
            v_prev <= v_cur;
        end
    end

    assign frame_start = v_prev & ~v_cur;

endmodule

// File: rtl/race_game_ctrl.sv
// ---------------------------------------------------------------------------
// race_game_ctrl
// Purpose : frame-synchronous game sequencer for the car-racing VGA pipeline.
//           Owns game state, level, road-scroll pacing and the player-car
//           position commit. Positions are only committed on frame_start so
//           the car never tears mid-frame.
// Ports   :
//   clk  in   pixel clock (only clock)
//   rst  in   synchronous reset, active-high
//   bus  race_game_ctrl_if.slave (see interface file for the signal list)
// Build option: define PAUSE_EN to add pause_req and an internal PAUSE
//           state; without it the machine is IDLE/PLAY/CRASH/WIN only.
// ---------------------------------------------------------------------------
module race_game_ctrl
    import race_game_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    race_game_ctrl_if.slave bus
);

    state_t     state;
    logic [9:0] car_x_q;
    logic [9:0] car_y_q;
    logic [9:0] pend_x;
    logic [9:0] pend_y;
    logic       pend_vld;
    logic       col_latch;
    logic [1:0] level_q;
    logic [3:0] div_cnt;
    logic [7:0] hold_cnt;

    logic       frame_start;
    logic       crash_now;
    logic       win_now;
    logic       tick_due;

    race_game_ctrl_frame_tick_gen u_frame_tick (
        .clk         (clk),
        .rst         (rst),
        .v_sync      (bus.v_sync),
        .frame_start (frame_start)
    );

    // A collision pulse on the frame_start cycle itself counts, even though
    // the latch has not captured it yet.
    assign crash_now = col_latch | bus.collision;
    assign win_now   = (bus.score >= WIN_SCORE);

    // ">=" rather than "==" so that a drop to a smaller divisor (level up)
    // never leaves the counter stranded above the new terminal value.
    assign tick_due  = (div_cnt >= (div_of(level_q) - 4'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            car_x_q   <= START_X;
            car_y_q   <= START_Y;
            pend_x    <= 10'd0;
            pend_y    <= 10'd0;
            pend_vld  <= 1'b0;
            col_latch <= 1'b0;
            level_q   <= 2'd0;
            div_cnt   <= 4'd0;
            hold_cnt  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_req) begin
                        state     <= ST_PLAY;
                        car_x_q   <= START_X;
                        car_y_q   <= START_Y;
                        level_q   <= 2'd0;
                        div_cnt   <= 4'd0;
                        pend_vld  <= 1'b0;
                        col_latch <= 1'b0;
                    end
                end

                ST_PLAY: begin
                    if (bus.pos_wr) begin
                        pend_x   <= bus.pos_x;
                        pend_y   <= bus.pos_y;
                        pend_vld <= 1'b1;
                    end
                    if (bus.collision) begin
                        col_latch <= 1'b1;
                    end
                    if (frame_start) begin
                        // These override the captures above: a same-cycle
                        // write is committed directly and the latch is
                        // consumed by this frame's evaluation.
                        col_latch <= 1'b0;
                        pend_vld  <= 1'b0;
                        if (bus.pos_wr) begin
                            car_x_q <= clamp10(bus.pos_x, X_MIN, X_MAX);
                            car_y_q <= clamp10(bus.pos_y, Y_MIN, Y_MAX);
                        end else if (pend_vld) begin
                            car_x_q <= clamp10(pend_x, X_MIN, X_MAX);
                            car_y_q <= clamp10(pend_y, Y_MIN, Y_MAX);
                        end
                        // Pacing uses the level in force during the frame
                        // just ended; the new level applies from the next.
                        level_q  <= level_of(bus.score);
                        div_cnt  <= tick_due ? 4'd0 : (div_cnt + 4'd1);
                        hold_cnt <= 8'd0;
                        if (crash_now) begin
                            state <= ST_CRASH;
                        end else if (win_now) begin
                            state <= ST_WIN;
                        end
`ifdef PAUSE_EN
                        else if (bus.pause_req) begin
                            state <= ST_PAUSE;
                        end
`endif
                    end
`ifdef PAUSE_EN
                    else if (bus.pause_req) begin
                        state <= ST_PAUSE;
                    end
`endif
                end

                ST_CRASH, ST_WIN: begin
                    if (frame_start) begin
                        if (hold_cnt == (HOLD_FRAMES - 8'd1)) begin
                            state    <= ST_IDLE;
                            hold_cnt <= 8'd0;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end

`ifdef PAUSE_EN
                ST_PAUSE: begin
                    // Everything is frozen; collisions are not remembered.
                    col_latch <= 1'b0;
                    if (bus.pause_req) begin
                        state <= ST_PLAY;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.car_x       = car_x_q;
    assign bus.car_y       = car_y_q;
    assign bus.level       = level_q;
    assign bus.game_state  = (state == ST_PAUSE) ? 2'b01 : state[1:0];
    assign bus.scroll_tick = (state == ST_PLAY) && frame_start && tick_due;
    assign bus.frame_start = frame_start;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_race_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_race_game_ctrl
// Purpose : self-checking bench for race_game_ctrl. Frames are short
//           (FRAME_LEN cycles, v_sync low for the first two), so the bench
//           always knows which cycle carries frame_start (frame position 1).
// ---------------------------------------------------------------------------
module tb_race_game_ctrl;

    localparam int FRAME_LEN = 16;

    logic clk;
    logic rst;
    int   fpos;
    int   n_cmp;
    int   n_bad;
    logic [19:0] exp_q[$];

    race_game_ctrl_if bus ();

    race_game_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference helpers ----------------
    function automatic int exp_level(input int s);
        if (s < 10) return 0;
        if (s < 20) return 1;
        if (s < 30) return 2;
        return 3;
    endfunction

    function automatic int exp_div(input int lv);
        return 4 - lv;
    endfunction

    function automatic int clampv(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one clock: inputs settle 1 time unit after the edge, pulses
    // are cleared and the v_sync pattern moves on.
    task automatic cyc();
        @(posedge clk);
        #1;
        bus.start_req = 1'b0;
        bus.pos_wr    = 1'b0;
        bus.collision = 1'b0;
`ifdef PAUSE_EN
        bus.pause_req = 1'b0;
`endif
        fpos       = (fpos + 1) % FRAME_LEN;
        bus.v_sync = (fpos >= 2);
    endtask

    task automatic to_frame_start();
        do cyc(); while (fpos != 1);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        fpos          = 5;
        bus.v_sync    = 1'b1;
        bus.start_req = 1'b0;
        bus.pos_wr    = 1'b0;
        bus.pos_x     = 10'd0;
        bus.pos_y     = 10'd0;
        bus.score     = 6'd0;
        bus.collision = 1'b0;
`ifdef PAUSE_EN
        bus.pause_req = 1'b0;
`endif
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    task automatic start_game();
        cyc();
        bus.start_req = 1'b1;
        cyc();
    endtask

    task automatic write_pos(input int x, input int y);
        bus.pos_wr = 1'b1;
        bus.pos_x  = 10'(x);
        bus.pos_y  = 10'(y);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp += 6;
        if (bus.game_state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.game_state); end
        if (bus.car_x !== 10'd300) begin n_bad++; $display("FAIL reset_car_x: got %0d want 300", bus.car_x); end
        if (bus.car_y !== 10'd429) begin n_bad++; $display("FAIL reset_car_y: got %0d want 429", bus.car_y); end
        if (bus.level !== 2'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        if (bus.scroll_tick !== 1'b0) begin n_bad++; $display("FAIL reset_scroll: got %0b want 0", bus.scroll_tick); end
        if (bus.frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start: got %0b want 0", bus.frame_start); end
    endtask

    task automatic test_start();
        do_reset();
        cyc();
        @(negedge clk);
        n_cmp++;
        if (bus.game_state !== 2'b00) begin n_bad++; $display("FAIL start_idle: got %0d want 0", bus.game_state); end
        start_game();
        @(negedge clk);
        n_cmp += 3;
        if (bus.game_state !== 2'b01) begin n_bad++; $display("FAIL start_play: got %0d want 1", bus.game_state); end
        if (bus.car_x !== 10'd300 || bus.car_y !== 10'd429) begin
            n_bad++; $display("FAIL start_car: got (%0d,%0d) want (300,429)", bus.car_x, bus.car_y);
        end
        if (bus.level !== 2'd0) begin n_bad++; $display("FAIL start_level: got %0d want 0", bus.level); end
    endtask

    task automatic test_pacing();
        logic want;
        do_reset();
        start_game();
        bus.score = 6'd0;
        for (int f = 1; f <= 12; f++) begin
            to_frame_start();
            @(negedge clk);
            want = ((f % 4) == 0);
            n_cmp++;
            if (bus.scroll_tick !== want) begin
                n_bad++; $display("FAIL pace_lvl0 frame %0d: got %0b want %0b", f, bus.scroll_tick, want);
            end
            cyc();
            n_cmp++;
            if (bus.scroll_tick !== 1'b0) begin n_bad++; $display("FAIL pace_midframe: got %0b want 0", bus.scroll_tick); end
        end
        bus.score = 6'd35;
        for (int f = 13; f <= 18; f++) begin
            to_frame_start();
            @(negedge clk);
            want = (f != 13);
            n_cmp++;
            if (bus.scroll_tick !== want) begin
                n_bad++; $display("FAIL pace_lvl3 frame %0d: got %0b want %0b", f, bus.scroll_tick, want);
            end
            cyc();
            n_cmp++;
            if (bus.level !== 2'd3) begin n_bad++; $display("FAIL pace_level: got %0d want 3", bus.level); end
        end
    endtask

    task automatic test_clamp();
        do_reset();
        start_game();
        write_pos(500, 10);
        cyc();
        @(negedge clk);
        n_cmp++;
        if (bus.car_x !== 10'd300 || bus.car_y !== 10'd429) begin
            n_bad++; $display("FAIL clamp_early: got (%0d,%0d) want (300,429)", bus.car_x, bus.car_y);
        end
        to_frame_start();
        @(negedge clk);
        n_cmp++;
        if (bus.car_x !== 10'd300 || bus.car_y !== 10'd429) begin
            n_bad++; $display("FAIL clamp_at_fs: got (%0d,%0d) want (300,429)", bus.car_x, bus.car_y);
        end
        cyc();
        n_cmp++;
        if (bus.car_x !== 10'd368 || bus.car_y !== 10'd40) begin
            n_bad++; $display("FAIL clamp_commit: got (%0d,%0d) want (368,40)", bus.car_x, bus.car_y);
        end
        // Write on the frame_start cycle itself is committed immediately.
        to_frame_start();
        write_pos(100, 1000);
        cyc();
        n_cmp++;
        if (bus.car_x !== 10'd269 || bus.car_y !== 10'd429) begin
            n_bad++; $display("FAIL clamp_bypass: got (%0d,%0d) want (269,429)", bus.car_x, bus.car_y);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_game();
        write_pos(320, 200);
        cyc();
        write_pos(333, 111);
        cyc();
        to_frame_start();
        cyc();
        n_cmp++;
        if (bus.car_x !== 10'd333 || bus.car_y !== 10'd111) begin
            n_bad++; $display("FAIL b2b_last_wins: got (%0d,%0d) want (333,111)", bus.car_x, bus.car_y);
        end
    endtask

    task automatic test_random_play();
        int m_since, m_level, m_x, m_y, s, wr_at, px, py;
        bit do_wr, m_pend;
        logic want_tick;
        logic [19:0] exp_pos;
        do_reset();
        start_game();
        m_since = 0; m_level = 0; m_x = 300; m_y = 429;
        for (int f = 0; f < 40; f++) begin
            s         = $urandom_range(0, 39);
            bus.score = s[5:0];
            do_wr     = ($urandom_range(0, 3) != 0);
            wr_at     = $urandom_range(3, FRAME_LEN + 1) % FRAME_LEN;
            px        = $urandom_range(0, 1023);
            py        = $urandom_range(0, 1023);
            m_pend    = 1'b0;
            while (fpos != 1) begin
                cyc();
                if (do_wr && fpos == wr_at) begin
                    write_pos(px, py);
                    m_pend = 1'b1;
                end
            end
            @(negedge clk);
            want_tick = ((m_since + 1) >= exp_div(m_level));
            n_cmp += 2;
            if (bus.frame_start !== 1'b1) begin n_bad++; $display("FAIL rnd_frame_start f%0d: got %0b want 1", f, bus.frame_start); end
            if (bus.scroll_tick !== want_tick) begin
                n_bad++; $display("FAIL rnd_tick f%0d: got %0b want %0b", f, bus.scroll_tick, want_tick);
            end
            m_since = want_tick ? 0 : m_since + 1;
            m_level = exp_level(s);
            if (m_pend) begin
                m_x = clampv(px, 269, 368);
                m_y = clampv(py, 40, 429);
            end
            exp_q.push_back({10'(m_x), 10'(m_y)});
            cyc();
            exp_pos = exp_q.pop_front();
            n_cmp += 3;
            if ({bus.car_x, bus.car_y} !== exp_pos) begin
                n_bad++; $display("FAIL rnd_car f%0d: got (%0d,%0d) want (%0d,%0d)", f, bus.car_x, bus.car_y, exp_pos[19:10], exp_pos[9:0]);
            end
            if (bus.level !== 2'(m_level)) begin n_bad++; $display("FAIL rnd_level f%0d: got %0d want %0d", f, bus.level, m_level); end
            if (bus.game_state !== 2'b01) begin n_bad++; $display("FAIL rnd_state f%0d: got %0d want 1", f, bus.game_state); end
        end
    endtask

    task automatic test_crash_hold();
        do_reset();
        start_game();
        bus.score     = 6'd40;
        bus.collision = 1'b1;
        cyc();
        @(negedge clk);
        n_cmp++;
        if (bus.game_state !== 2'b01) begin n_bad++; $display("FAIL crash_before_fs: got %0d want 1", bus.game_state); end
        to_frame_start();
        cyc();
        n_cmp++;
        if (bus.game_state !== 2'b10) begin n_bad++; $display("FAIL crash_not_win: got %0d want 2", bus.game_state); end
        for (int k = 1; k <= 120; k++) begin
            if (k == 50) begin
                bus.start_req = 1'b1;
                cyc();
            end
            to_frame_start();
            @(negedge clk);
            n_cmp++;
            if (bus.scroll_tick !== 1'b0) begin n_bad++; $display("FAIL crash_scroll k%0d: got %0b want 0", k, bus.scroll_tick); end
            cyc();
            if (k == 50 || k == 119) begin
                n_cmp++;
                if (bus.game_state !== 2'b10) begin n_bad++; $display("FAIL crash_hold k%0d: got %0d want 2", k, bus.game_state); end
            end
        end
        n_cmp++;
        if (bus.game_state !== 2'b00) begin n_bad++; $display("FAIL crash_to_idle: got %0d want 0", bus.game_state); end
    endtask

    task automatic test_win();
        do_reset();
        start_game();
        bus.score = 6'd40;
        to_frame_start();
        cyc();
        n_cmp++;
        if (bus.game_state !== 2'b11) begin n_bad++; $display("FAIL win_state: got %0d want 3", bus.game_state); end
        to_frame_start();
        @(negedge clk);
        n_cmp += 2;
        if (bus.frame_start !== 1'b1) begin n_bad++; $display("FAIL win_fs: got %0b want 1", bus.frame_start); end
        if (bus.scroll_tick !== 1'b0) begin n_bad++; $display("FAIL win_scroll: got %0b want 0", bus.scroll_tick); end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        start_game();
        write_pos(320, 100);
        cyc();
        do_reset();
        @(negedge clk);
        n_cmp += 2;
        if (bus.game_state !== 2'b00) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", bus.game_state); end
        if (bus.scroll_tick !== 1'b0) begin n_bad++; $display("FAIL midrst_scroll: got %0b want 0", bus.scroll_tick); end
        write_pos(330, 200); // dropped: not in PLAY
        cyc();
        start_game();
        to_frame_start();
        cyc();
        n_cmp++;
        if (bus.car_x !== 10'd300 || bus.car_y !== 10'd429) begin
            n_bad++; $display("FAIL midrst_pending: got (%0d,%0d) want (300,429)", bus.car_x, bus.car_y);
        end
    endtask

`ifdef PAUSE_EN
    task automatic test_pause();
        do_reset();
        start_game();
        bus.score = 6'd0;
        to_frame_start();
        to_frame_start();
        cyc();
        bus.pause_req = 1'b1;
        cyc();
        @(negedge clk);
        n_cmp++;
        if (bus.game_state !== 2'b01) begin n_bad++; $display("FAIL pause_state: got %0d want 1", bus.game_state); end
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) begin
                write_pos(320, 200);
                bus.collision = 1'b1;
                cyc();
            end
            to_frame_start();
            @(negedge clk);
            n_cmp++;
            if (bus.scroll_tick !== 1'b0) begin n_bad++; $display("FAIL pause_scroll k%0d: got %0b want 0", k, bus.scroll_tick); end
            cyc();
            n_cmp++;
            if (bus.car_x !== 10'd300 || bus.game_state !== 2'b01) begin
                n_bad++; $display("FAIL pause_frozen k%0d: got x=%0d st=%0d want x=300 st=1", k, bus.car_x, bus.game_state);
            end
        end
        bus.pause_req = 1'b1;
        cyc();
        to_frame_start();
        @(negedge clk);
        n_cmp++;
        if (bus.scroll_tick !== 1'b0) begin n_bad++; $display("FAIL resume_third: got %0b want 0", bus.scroll_tick); end
        to_frame_start();
        @(negedge clk);
        n_cmp++;
        if (bus.scroll_tick !== 1'b1) begin n_bad++; $display("FAIL resume_fourth: got %0b want 1", bus.scroll_tick); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        fpos  = 5;
        rst   = 1'b1;
        bus.v_sync    = 1'b1;
        bus.start_req = 1'b0;
        bus.pos_wr    = 1'b0;
        bus.pos_x     = 10'd0;
        bus.pos_y     = 10'd0;
        bus.score     = 6'd0;
        bus.collision = 1'b0;
`ifdef PAUSE_EN
        bus.pause_req = 1'b0;
`endif
        test_reset();
        test_start();
        test_pacing();
        test_clamp();
        test_back_to_back();
        test_random_play();
        test_crash_hold();
        test_win();
        test_reset_mid_play();
`ifdef PAUSE_EN
        test_pause();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
